sequence_detector: RTL and testbench

//  - Serial bit-pattern detector: samples input 'in' on every rising clock edge and flags completion of PATTERN.
//  - Pattern is MSB-first, with overlapping detection by default.
//  - Moore machine with a registered output; the flag is high for exactly one cycle per match.
//  - Leaf block for serial-stream front ends (framing/sync-word detection).

---
 rtl/sequence_detector_pkg.sv | 26 ++
 rtl/sequence_detector.sv | 93 +++++++++
 tb/tb_sequence_detector.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_detector_pkg.sv
// Shared helpers for the serial pattern detector: width arithmetic used to
// size the matched-prefix state register.
package sequence_detector_pkg;

    // Largest pattern length the detector is meant to be built with.
    localparam int MAX_PAT_LEN = 16;

    // Ceiling log2, never smaller than 1 so a register always has a bit.
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    // Bits needed to hold a matched-prefix count of 0..pat_len.
    function automatic int state_w(input int pat_len);
        return clog2_w(pat_len + 1);
    endfunction

    // State width of the widest legal configuration.
    localparam int MAX_STATE_W = state_w(MAX_PAT_LEN);

endpackage

// File: rtl/sequence_detector.sv
// Serial bit-pattern detector (Moore, registered flag). The state is the
// number of pattern-prefix bits currently matched; transitions come from a
// KMP-style table built at elaboration time from PATTERN.
module sequence_detector
    import sequence_detector_pkg::*;
#(
    parameter int               PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int SW    = state_w(PAT_LEN);
    localparam int ENT_W = SW + 1;            // {hit, next_state}
    localparam int NENT  = 1 << (SW + 1);     // indexed by {state, in}
    localparam int TBL_W = ENT_W * NENT;

    // Builds the {hit, next} entry for every {state, in}. The received string
    // is the matched prefix followed by the new bit; next state is the
    // longest pattern prefix that is also a suffix of it, capped below
    // PAT_LEN so a full match falls back to its longest proper border.
    function automatic logic [TBL_W-1:0] build_table();
        logic [TBL_W-1:0] t;
        logic [PAT_LEN:0] s;
        int               k;
        int               jmax;
        int               best;
        logic             b;
        logic             hit;
        logic             eq;
        t = '0;
        for (int e = 0; e < NENT; e++) begin
            k = e / 2;
            b = ((e % 2) != 0);
            if (k < PAT_LEN) begin
                s = '0;
                for (int i = 0; i < k; i++) begin
                    s[i] = PATTERN[PAT_LEN-1-i];
                end
                s[k] = b;
                hit  = (k == PAT_LEN - 1) && (b == PATTERN[0]);
                jmax = (k + 1 < PAT_LEN - 1) ? k + 1 : PAT_LEN - 1;
                best = 0;
                for (int j = 1; j <= jmax; j++) begin
                    eq = 1'b1;
                    for (int i = 0; i < j; i++) begin
                        if (PATTERN[PAT_LEN-1-i] != s[k+1-j+i]) begin
                            eq = 1'b0;
                        end
                    end
                    if (eq) begin
                        best = j;
                    end
                end
                if (hit && !OVERLAP) begin
                    best = 0;
                end
                t[e*ENT_W +: ENT_W] = {hit, best[SW-1:0]};
            end
        end
        return t;
    endfunction

    localparam logic [TBL_W-1:0] TABLE = build_table();

    logic [SW-1:0] state;
    logic [SW-1:0] state_d;
    logic          hit_d;
    logic [SW:0]   entry;

    // Look up the next state and match flag for the current state and bit.
    always_comb begin
        entry   = TABLE[ENT_W*int'({state, in}) +: ENT_W];
        state_d = entry[SW-1:0];
        hit_d   = entry[SW];
    end

    // State and registered detect flag; reset drops both immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_d;
            out   <= hit_d;
        end
    end

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector: default 1011 detector with and
// without overlap, plus a 3-bit 111 detector with and without overlap.
module tb_sequence_detector;

    logic clock;
    logic reset;
    logic din;
    logic out_def;
    logic out_nov;
    logic out_3;
    logic out_3n;

    int checks;
    int failures;

    sequence_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) d_def (
        .clock(clock), .reset(reset), .in(din), .out(out_def));
    sequence_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) d_nov (
        .clock(clock), .reset(reset), .in(din), .out(out_nov));
    sequence_detector #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1)) d_3 (
        .clock(clock), .reset(reset), .in(din), .out(out_3));
    sequence_detector #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b0)) d_3n (
        .clock(clock), .reset(reset), .in(din), .out(out_3n));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one bit at the falling edge, let the rising edge sample it.
    task automatic step(input logic b);
        @(negedge clock);
        din = b;
        @(posedge clock);
        #1;
    endtask

    // Synchronising reset pulse spanning one rising edge.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        din   = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] bits;
        logic [3:0] exp;
        bits = 4'b1011;
        exp  = 4'b0001;
        do_reset();
        checks++;
        if ({out_def, out_nov, out_3, out_3n} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_out: got %b want 0000", {out_def, out_nov, out_3, out_3n});
        end
        checks++;
        if (d_def.state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d want 0", d_def.state);
        end
        for (int i = 0; i < 4; i++) begin
            step(bits[3-i]);
            checks++;
            if (out_def !== exp[3-i]) begin
                failures++;
                $display("FAIL reset_pre bit %0d: got %b want %b", i + 1, out_def, exp[3-i]);
            end
        end
        // out is high here; asynchronous reset must clear it without a clock
        reset = 1'b1;
        #1;
        checks++;
        if (out_def !== 1'b0) begin
            failures++;
            $display("FAIL async_clear_out: got %b want 0", out_def);
        end
        @(negedge clock);
        reset = 1'b0;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        checks++;
        if (d_def.state !== 2'd3) begin
            failures++;
            $display("FAIL reach_s3: got %0d want 3", d_def.state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (d_def.state !== 2'd0 || out_def !== 1'b0) begin
            failures++;
            $display("FAIL async_s3: state=%0d out=%b want state=0 out=0", d_def.state, out_def);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(bits[3-i]);
            checks++;
            if (out_def !== exp[3-i]) begin
                failures++;
                $display("FAIL reset_post bit %0d: got %b want %b", i + 1, out_def, exp[3-i]);
            end
        end
        step(1'b0);
        checks++;
        if (out_def !== 1'b0) begin
            failures++;
            $display("FAIL reset_post_width: got %b want 0", out_def);
        end
    endtask

    task automatic test_long_stream();
        logic [14:0] bits;
        logic [14:0] exp;
        bits = 15'b010101101101101;
        exp  = 15'b000000100100100;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(bits[14-i]);
            checks++;
            if (out_def !== exp[14-i]) begin
                failures++;
                $display("FAIL long_stream bit %0d: got %b want %b", i + 1, out_def, exp[14-i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] bits;
        logic [6:0] exp_ov;
        logic [6:0] exp_no;
        bits   = 7'b1011011;
        exp_ov = 7'b0001001;
        exp_no = 7'b0001000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(bits[6-i]);
            checks++;
            if (out_def !== exp_ov[6-i]) begin
                failures++;
                $display("FAIL b2b_overlap bit %0d: got %b want %b", i + 1, out_def, exp_ov[6-i]);
            end
            checks++;
            if (out_nov !== exp_no[6-i]) begin
                failures++;
                $display("FAIL b2b_nooverlap bit %0d: got %b want %b", i + 1, out_nov, exp_no[6-i]);
            end
        end
    endtask

    task automatic test_near_miss();
        logic [5:0] bits_a;
        logic [5:0] bits_b;
        logic [5:0] exp;
        bits_a = 6'b101011;
        bits_b = 6'b111011;
        exp    = 6'b000001;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(bits_a[5-i]);
            checks++;
            if (out_def !== exp[5-i]) begin
                failures++;
                $display("FAIL near_miss_a bit %0d: got %b want %b", i + 1, out_def, exp[5-i]);
            end
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(bits_b[5-i]);
            checks++;
            if (out_def !== exp[5-i]) begin
                failures++;
                $display("FAIL near_miss_b bit %0d: got %b want %b", i + 1, out_def, exp[5-i]);
            end
        end
    endtask

    task automatic test_constant_input();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            checks++;
            if (out_def !== 1'b0) begin
                failures++;
                $display("FAIL all_zero cycle %0d: got %b want 0", i + 1, out_def);
            end
        end
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            checks++;
            if (out_def !== 1'b0) begin
                failures++;
                $display("FAIL all_one cycle %0d: got %b want 0", i + 1, out_def);
            end
        end
    endtask

    task automatic test_short_pattern();
        logic [5:0] exp_ov;
        logic [5:0] exp_no;
        exp_ov = 6'b001111;
        exp_no = 6'b001001;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            checks++;
            if (out_3 !== exp_ov[5-i]) begin
                failures++;
                $display("FAIL p111_overlap bit %0d: got %b want %b", i + 1, out_3, exp_ov[5-i]);
            end
            checks++;
            if (out_3n !== exp_no[5-i]) begin
                failures++;
                $display("FAIL p111_nooverlap bit %0d: got %b want %b", i + 1, out_3n, exp_no[5-i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        din      = 1'b0;
        repeat (2) @(posedge clock);
        test_reset();
        test_long_stream();
        test_back_to_back();
        test_near_miss();
        test_constant_input();
        test_short_pattern();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
